// File: rtl/traffic_pkg.sv
// traffic_pkg: state codes, state width and small helpers shared by the traffic-light controller.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package traffic_pkg;

  localparam int STATE_W = 2;

  // Code 2'b11 is deliberately unused; the FSM treats it as a fault and returns to green.
  typedef enum logic [STATE_W-1:0] {
    ST_GREEN  = 2'b00,
    ST_YELLOW = 2'b01,
    ST_RED    = 2'b10
  } state_t;

  // Lamp vector {green, yellow, red} for a state; an illegal code shows green so a lamp is always lit.
  function automatic logic [2:0] lamps_of(input state_t s);
    logic [2:0] l;
    l = 3'b100;
    case (s)
      ST_GREEN:  l = 3'b100;
      ST_YELLOW: l = 3'b010;
      ST_RED:    l = 3'b001;
      default:   l = 3'b100;
    endcase
    return l;
  endfunction

  // Largest of three phase lengths, used to size-check the timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// phase_timer: per-phase cycle counter with synchronous clear and saturation at a runtime limit.
// Latency: count visible one cycle after the edge that clears or advances it.
// Backpressure: none; the counter holds at lim and never wraps.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] lim,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear has priority; otherwise count up while below the limit and hold there.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q < lim)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (res) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/traffic_light_timed.sv
// traffic_light_timed: main-road light, GREEN (min GRN_MIN, until requested) -> YELLOW -> RED -> GREEN.
// Latency: lamps, STATE and TMR are registered; a request seen at the GREEN limit leaves GREEN on that edge.
// Backpressure: none; CAR (and PED when `PED_REQ_EN is defined) are sampled every cycle.
module traffic_light_timed
  import traffic_pkg::*;
#(
  parameter int GRN_MIN  = 8,
  parameter int YLW_TIME = 3,
  parameter int RED_TIME = 6,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             CAR,
`ifdef PED_REQ_EN
  input  logic             PED,
  output logic             WALK,
`endif
  output logic             GRN,
  output logic             YLW,
  output logic             RED,
  output logic [1:0]       STATE,
  output logic [CNT_W-1:0] TMR
);

  localparam int MAX_P = max3(GRN_MIN, YLW_TIME, RED_TIME);
  localparam logic [CNT_W-1:0] GRN_LIM = CNT_W'(GRN_MIN - 1);
  localparam logic [CNT_W-1:0] YLW_LIM = CNT_W'(YLW_TIME - 1);
  localparam logic [CNT_W-1:0] RED_LIM = CNT_W'(RED_TIME - 1);

  // Every phase needs at least one cycle and the timer must reach the longest phase limit.
  if ((GRN_MIN < 1) || (YLW_TIME < 1) || (RED_TIME < 1) || (CNT_W < 1) ||
      ((CNT_W < 31) && ((MAX_P - 1) >= (1 << CNT_W)))) begin : g_param_err
    $error("traffic_light_timed: bad parameters (phases must be >= 1, CNT_W must hold max phase - 1)");
  end

  state_t           state_q;
  state_t           state_d;
  logic             pend_q;
  logic             pend_d;
  logic             grn_q;
  logic             ylw_q;
  logic             red_q;
  logic [2:0]       lamps_d;
  logic             req;
  logic             go;
  logic             tmr_clr;
  logic [CNT_W-1:0] tmr_lim;
  logic [CNT_W-1:0] tmr;

`ifdef PED_REQ_EN
  assign req = CAR | PED;
`else
  assign req = CAR;
`endif

  // Next state, pending request and timer control; a state change always restarts the timer.
  always_comb begin
    state_d = state_q;
    go      = 1'b0;
    pend_d  = pend_q;
    tmr_lim = '0;
    case (state_q)
      ST_GREEN: begin
        tmr_lim = GRN_LIM;
        if ((tmr == GRN_LIM) && (req || pend_q)) begin
          go      = 1'b1;
          state_d = ST_YELLOW;
        end
        // A short request before the minimum green is latched; it is consumed on leaving GREEN.
        pend_d = go ? 1'b0 : (pend_q | req);
      end
      ST_YELLOW: begin
        tmr_lim = YLW_LIM;
        if (tmr == YLW_LIM) state_d = ST_RED;
      end
      ST_RED: begin
        tmr_lim = RED_LIM;
        if (tmr == RED_LIM) state_d = ST_GREEN;
      end
      default: begin
        state_d = ST_GREEN;
      end
    endcase
    tmr_clr = (state_d != state_q);
    lamps_d = lamps_of(state_d);
  end

  // FSM state, pending flag and lamp registers; lamps follow the state register one-for-one.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= ST_GREEN;
      pend_q  <= 1'b0;
      grn_q   <= 1'b1;
      ylw_q   <= 1'b0;
      red_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      grn_q   <= lamps_d[2];
      ylw_q   <= lamps_d[1];
      red_q   <= lamps_d[0];
    end
  end

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk (clk),
    .res (res),
    .clr (tmr_clr),
    .en  (1'b1),
    .lim (tmr_lim),
    .cnt (tmr)
  );

`ifdef PED_REQ_EN
  logic ped_seen_q;
  logic ped_seen_d;
  logic walk_q;
  logic walk_d;
  logic walk_out_q;
  logic walk_out_d;

  // Track a pedestrian press within the current GREEN and carry it to RED as a walk grant.
  always_comb begin
    ped_seen_d = ped_seen_q;
    walk_d     = walk_q;
    if (state_q == ST_GREEN) begin
      ped_seen_d = go ? 1'b0 : (ped_seen_q | PED);
      if (go) walk_d = ped_seen_q | PED;
    end else if ((state_q == ST_RED) && (state_d != ST_RED)) begin
      walk_d = 1'b0;
    end
    walk_out_d = walk_d & (state_d == ST_RED);
  end

  // Walk flag and registered WALK lamp.
  always_ff @(posedge clk) begin
    if (res) begin
      ped_seen_q <= 1'b0;
      walk_q     <= 1'b0;
      walk_out_q <= 1'b0;
    end else begin
      ped_seen_q <= ped_seen_d;
      walk_q     <= walk_d;
      walk_out_q <= walk_out_d;
    end
  end

  assign WALK = walk_out_q;
`endif

  assign GRN   = grn_q;
  assign YLW   = ylw_q;
  assign RED   = red_q;
  assign STATE = state_q;
  assign TMR   = tmr;

endmodule

// File: tb/tb_traffic_light_timed.sv
// tb_traffic_light_timed: directed checks of the timed traffic light (4/2/3 instance plus an all-ones instance).
// Latency: outputs sampled on the falling edge, half a cycle after each rising edge.
// Backpressure: n/a.
module tb_traffic_light_timed;
  import traffic_pkg::*;

  localparam logic [2:0] L_G = 3'b100;
  localparam logic [2:0] L_Y = 3'b010;
  localparam logic [2:0] L_R = 3'b001;

  logic       clk;
  logic       res;
  logic       car;
  logic       grn, ylw, red;
  logic [1:0] state;
  logic [7:0] tmr;
  logic [2:0] lamps;

  logic       res_m;
  logic       car_m;
  logic       grn_m, ylw_m, red_m;
  logic [1:0] state_m;
  logic [7:0] tmr_m;
  logic [2:0] lamps_m;

`ifdef PED_REQ_EN
  logic ped;
  logic walk;
  logic ped_m;
  logic walk_m;
`endif

  int n_total;
  int n_pass;
  int cyc;

  assign lamps   = {grn, ylw, red};
  assign lamps_m = {grn_m, ylw_m, red_m};

  traffic_light_timed #(
    .GRN_MIN (4), .YLW_TIME (2), .RED_TIME (3), .CNT_W (8)
  ) u_dut (
    .clk   (clk),
    .res   (res),
    .CAR   (car),
`ifdef PED_REQ_EN
    .PED   (ped),
    .WALK  (walk),
`endif
    .GRN   (grn),
    .YLW   (ylw),
    .RED   (red),
    .STATE (state),
    .TMR   (tmr)
  );

  traffic_light_timed #(
    .GRN_MIN (1), .YLW_TIME (1), .RED_TIME (1), .CNT_W (8)
  ) u_min (
    .clk   (clk),
    .res   (res_m),
    .CAR   (car_m),
`ifdef PED_REQ_EN
    .PED   (ped_m),
    .WALK  (walk_m),
`endif
    .GRN   (grn_m),
    .YLW   (ylw_m),
    .RED   (red_m),
    .STATE (state_m),
    .TMR   (tmr_m)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
  endtask

  // One rising edge, then settle to the falling edge where outputs are sampled.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  // One reset edge; afterwards we sit in cycle 0 of a fresh GREEN.
  task automatic do_reset();
    res = 1'b1;
    step();
    res = 1'b0;
    cyc = 0;
  endtask

  initial begin
    logic [2:0] exp_l;
    logic [7:0] exp_t;
    int         m;
    clk = 1'b0; res = 1'b1; car = 1'b0; res_m = 1'b1; car_m = 1'b0;
    n_total = 0; n_pass = 0; cyc = 0;
`ifdef PED_REQ_EN
    ped = 1'b0; ped_m = 1'b0;
`endif

    // Reset values, with CAR high during reset (must be discarded).
    car = 1'b1;
    @(negedge clk);
    step();
    chk("reset_lamps", lamps, L_G);
    chk("reset_state", state, 2'b00);
    chk("reset_tmr", tmr, 8'd0);
    res = 1'b0; car = 1'b0; cyc = 0;
    run_to(10);
    chk("car_in_reset_dropped", lamps, L_G);
    chk("green_tmr_saturates", tmr, 8'd3);

    // CAR held high: G 0-3, Y 4-5, R 6-8, repeating every 9 cycles.
    do_reset();
    car = 1'b1;
    for (int c = 0; c < 19; c++) begin
      if (c > 0) step();
      m = c % 9;
      if (m < 4) begin exp_l = L_G; exp_t = 8'(m); end
      else if (m < 6) begin exp_l = L_Y; exp_t = 8'(m - 4); end
      else begin exp_l = L_R; exp_t = 8'(m - 6); end
      chk($sformatf("held_lamps_c%0d", c), lamps, exp_l);
      chk($sformatf("held_tmr_c%0d", c), tmr, exp_t);
    end

    // Single-cycle CAR pulse at cycle 1 is latched and served at the minimum green.
    do_reset();
    car = 1'b0;
    step();
    car = 1'b1;
    step();
    car = 1'b0;
    run_to(3);
    chk("pulse_c3_green", lamps, L_G);
    run_to(4);
    chk("pulse_c4_yellow", lamps, L_Y);
    chk("pulse_c4_state", state, 2'b01);
    run_to(6);
    chk("pulse_c6_red", lamps, L_R);
    chk("pulse_c6_state", state, 2'b10);
    run_to(9);
    chk("pulse_c9_green", lamps, L_G);
    run_to(50);
    chk("idle_c50_green", lamps, L_G);
    chk("idle_c50_tmr", tmr, 8'd3);

    // CAR only during YELLOW/RED is ignored; GREEN holds after the cycle.
    do_reset();
    car = 1'b1;
    run_to(4);
    car = 1'b0;
    chk("yr_c4_yellow", lamps, L_Y);
    step();
    car = 1'b1;
    step();
    car = 1'b0;
    chk("yr_c6_red", lamps, L_R);
    step();
    car = 1'b1;
    step();
    car = 1'b0;
    run_to(9);
    chk("yr_c9_green", lamps, L_G);
    run_to(22);
    chk("yr_c22_hold", lamps, L_G);
    chk("yr_c22_tmr", tmr, 8'd3);

    // Reset in RED with CAR still high: back to GREEN, timer 0, nothing remembered.
    do_reset();
    car = 1'b1;
    run_to(7);
    chk("rst_red_before", lamps, L_R);
    res = 1'b1;
    step();
    chk("rst_red_lamps", lamps, L_G);
    chk("rst_red_tmr", tmr, 8'd0);
    chk("rst_red_state", state, 2'b00);
    res = 1'b0; car = 1'b0; cyc = 0;
    run_to(8);
    chk("rst_red_no_req", lamps, L_G);

    // A pending request from before reset is lost.
    do_reset();
    car = 1'b0;
    step();
    car = 1'b1;
    step();
    car = 1'b0;
    res = 1'b1;
    step();
    res = 1'b0; cyc = 0;
    run_to(8);
    chk("pend_lost_green", lamps, L_G);

    // Reset on the would-be GREEN->YELLOW edge wins.
    do_reset();
    car = 1'b1;
    run_to(3);
    res = 1'b1;
    step();
    chk("rst_over_go_lamps", lamps, L_G);
    chk("rst_over_go_tmr", tmr, 8'd0);
    res = 1'b0; car = 1'b0;

`ifdef PED_REQ_EN
    // PED pulse at cycle 2: served like CAR, WALK only during the following RED.
    do_reset();
    ped = 1'b0;
    run_to(2);
    ped = 1'b1;
    step();
    ped = 1'b0;
    run_to(4);
    chk("ped_c4_yellow", lamps, L_Y);
    run_to(5);
    chk("ped_c5_walk", walk, 1'b0);
    for (int c = 6; c < 9; c++) begin
      run_to(c);
      chk($sformatf("ped_c%0d_walk", c), walk, 1'b1);
    end
    run_to(9);
    chk("ped_c9_walk", walk, 1'b0);

    // CAR-only request never lights WALK.
    do_reset();
    car = 1'b1;
    for (int c = 6; c < 9; c++) begin
      run_to(c);
      chk($sformatf("caronly_c%0d_walk", c), walk, 1'b0);
    end
    car = 1'b0;
`endif

    // All phases of length 1 with CAR high: G, Y, R one cycle each.
    res_m = 1'b1; car_m = 1'b1;
    step();
    res_m = 1'b0; cyc = 0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) step();
      m = c % 3;
      exp_l = (m == 0) ? L_G : ((m == 1) ? L_Y : L_R);
      chk($sformatf("min_lamps_c%0d", c), lamps_m, exp_l);
      chk($sformatf("min_tmr_c%0d", c), tmr_m, 8'd0);
    end
    run_to(6);
    chk("min_c6_green", lamps_m, L_G);

    // Illegal state code 11 in place of GREEN (which would go YELLOW) must go to GREEN.
    force u_min.state_q = state_t'(2'b11);
    step();
    release u_min.state_q;
    chk("illegal_to_green", lamps_m, L_G);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
